// File: rtl/elevator_pkg.sv
// Shared constants for the elevator controller, the shaft plant model and the benches.
package elevator_pkg;

    // Motor command encoding on the ac bus
    localparam logic [1:0] AC_DOWN    = 2'd0;
    localparam logic [1:0] AC_STOP    = 2'd1;
    localparam logic [1:0] AC_UP      = 2'd2;
    localparam logic [1:0] AC_ILLEGAL = 2'd3;

    localparam int NUM_FLOORS = 4;

    // Door FSM: closed, open with dwell running, open with dwell expired
    typedef enum logic [1:0] {
        DOOR_CLOSED = 2'd0,
        DOOR_OPEN   = 2'd1,
        DOOR_HOLD   = 2'd2
    } door_state_e;

endpackage

// File: rtl/elevator_door_timer.sv
// Door FSM with dwell counter. The door opens only at a floor mark with the motor
// stopped and stays open for at least DOOR_CYCLES cycles. It stays open past that
// for as long as open is held.
module elevator_door_timer
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 4
) (
    input  logic clk,
    input  logic ff_reset,
    input  logic open_i,
    input  logic at_mark_i,
    input  logic ac_is_stop_i,
    output logic door_open_o,
    output logic fault_o
);

    localparam int              CNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    door_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and dwell counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge ff_reset) begin
        if (ff_reset) begin
            state_q <= DOOR_CLOSED;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and dwell countdown
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DOOR_CLOSED: begin
                if (open_i && at_mark_i && ac_is_stop_i) begin
                    state_d = DOOR_OPEN;
                    cnt_d   = CNT_LOAD;
                end
            end
            DOOR_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = open_i ? DOOR_HOLD : DOOR_CLOSED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DOOR_HOLD: begin
                if (!open_i) begin
                    state_d = DOOR_CLOSED;
                end
            end
            default: state_d = DOOR_CLOSED;
        endcase
    end

    assign door_open_o = (state_q != DOOR_CLOSED);

    // Open requested off a mark, or requested with the motor not stopped while closed
    assign fault_o = open_i && (!at_mark_i || (!ac_is_stop_i && (state_q == DOOR_CLOSED)));

endmodule

// File: rtl/elevator_shaft_model.sv
// Plant model of car and shaft: tracks car position in clock steps between floors,
// decodes the floor sensors, runs the door timer and latches protocol faults.
module elevator_shaft_model
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int START_FLOOR   = 1
) (
    input  logic       clk,
    input  logic       ff_reset,
    input  logic [1:0] ac,
    input  logic       open,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic [2:0] floor,
    output logic       moving,
    output logic       door_open,
    output logic       fault
);

    localparam int               POS_W     = $clog2(3 * TRAVEL_CYCLES + 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(3 * TRAVEL_CYCLES);
    localparam logic [POS_W-1:0] POS_RESET = POS_W'((START_FLOOR - 1) * TRAVEL_CYCLES);

    logic [POS_W-1:0]      pos_q, pos_d;
    logic [2:0]            floor_q, floor_d;
    logic                  moving_q;
    logic                  fault_q, fault_d;
    logic [NUM_FLOORS-1:0] at_floor;
    logic                  at_mark;
    logic                  door_open_w;
    logic                  door_fault;
    logic                  motion_fault;

    elevator_door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door (
        .clk          (clk),
        .ff_reset     (ff_reset),
        .open_i       (open),
        .at_mark_i    (at_mark),
        .ac_is_stop_i (ac == AC_STOP),
        .door_open_o  (door_open_w),
        .fault_o      (door_fault)
    );

    // Floor sensors decoded from the registered position: at most one is high
    always_comb begin
        at_floor = '0;
        for (int n = 0; n < NUM_FLOORS; n++) begin
            at_floor[n] = (pos_q == POS_W'(n * TRAVEL_CYCLES));
        end
    end

    assign at_mark = |at_floor;

    // Car motion; an open door freezes the car, and the illegal code acts as stop
    always_comb begin
        pos_d        = pos_q;
        motion_fault = 1'b0;
        if (ac == AC_ILLEGAL) begin
            motion_fault = 1'b1;
        end else if (!door_open_w) begin
            if (ac == AC_UP) begin
                if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
                else                  motion_fault = 1'b1;
            end else if (ac == AC_DOWN) begin
                if (pos_q != '0) pos_d = pos_q - 1'b1;
                else             motion_fault = 1'b1;
            end
        end
    end

    // Last-floor tracking (updates on the edge the car lands on a mark) and sticky fault
    always_comb begin
        floor_d = floor_q;
        for (int n = 0; n < NUM_FLOORS; n++) begin
            if (pos_d == POS_W'(n * TRAVEL_CYCLES)) floor_d = 3'(n + 1);
        end
        fault_d = fault_q | motion_fault | door_fault;
    end

    // Position, floor, motion and fault registers, cleared asynchronously
    always_ff @(posedge clk or posedge ff_reset) begin
        if (ff_reset) begin
            pos_q    <= POS_RESET;
            floor_q  <= 3'(START_FLOOR);
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            floor_q  <= floor_d;
            moving_q <= (pos_d != pos_q);
            fault_q  <= fault_d;
        end
    end

    assign S1        = at_floor[0];
    assign S2        = at_floor[1];
    assign S3        = at_floor[2];
    assign S4        = at_floor[3];
    assign floor     = floor_q;
    assign moving    = moving_q;
    assign door_open = door_open_w;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for the shaft plant model: directed scenarios followed by random commands,
// all compared against a behavioural model of car position, door and fault rules.
module tb_elevator_shaft_model;

    localparam int T     = 8;
    localparam int DC    = 4;
    localparam int SF    = 1;
    localparam int MAXP  = 3 * T;

    logic       clk;
    logic       ff_reset;
    logic [1:0] ac;
    logic       open;
    logic       S1, S2, S3, S4;
    logic [2:0] floor;
    logic       moving, door_open, fault;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int m_pos;
    int m_floor;
    int m_moving;
    int m_door;
    int m_age;
    int m_fault;

    elevator_shaft_model #(
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (DC),
        .START_FLOOR   (SF)
    ) dut (
        .clk       (clk),
        .ff_reset  (ff_reset),
        .ac        (ac),
        .open      (open),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .S4        (S4),
        .floor     (floor),
        .moving    (moving),
        .door_open (door_open),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_sensors();
        if (m_pos % T == 0) return 1 << (m_pos / T);
        return 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".S"},         {28'd0, S4, S3, S2, S1}, exp_sensors());
        check({tag, ".floor"},     {29'd0, floor},          m_floor);
        check({tag, ".moving"},    {31'd0, moving},         m_moving);
        check({tag, ".door_open"}, {31'd0, door_open},      m_door);
        check({tag, ".fault"},     {31'd0, fault},          m_fault);
    endtask

    task automatic model_reset();
        m_pos    = (SF - 1) * T;
        m_floor  = SF;
        m_moving = 0;
        m_door   = 0;
        m_age    = 0;
        m_fault  = 0;
    endtask

    // One clock edge of the plant, from the rules: closed door lets the car move,
    // door stays open at least DC cycles then closes on the first edge with open low.
    task automatic model_edge(input int a, input int o);
        int  np;
        bit  on_mark;
        bit  closed;
        np      = m_pos;
        closed  = (m_door == 0);
        on_mark = (m_pos % T == 0);
        if (a == 3) m_fault = 1;
        if (closed) begin
            if (a == 2) begin
                if (m_pos < MAXP) np = m_pos + 1; else m_fault = 1;
            end else if (a == 0) begin
                if (m_pos > 0) np = m_pos - 1; else m_fault = 1;
            end
        end
        if (o != 0 && (!on_mark || (a != 1 && closed))) m_fault = 1;
        if (!closed) begin
            if (m_age >= DC && o == 0) m_door = 0;
            else m_age++;
        end else if (o != 0 && a == 1 && on_mark) begin
            m_door = 1;
            m_age  = 1;
        end
        m_moving = (np != m_pos) ? 1 : 0;
        m_pos    = np;
        if (np % T == 0) m_floor = np / T + 1;
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit after the edge
    task automatic step(input logic [1:0] a, input logic o, input string tag);
        ac   = a;
        open = o;
        @(posedge clk);
        model_edge(int'(a), int'(o));
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must change without a clock
    task automatic apply_reset(input string tag);
        #2;
        ff_reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        ff_reset = 1'b0;
        ac       = 2'd1;
        open     = 1'b0;
    endtask

    initial begin
        ff_reset = 1'b0;
        ac       = 2'd1;
        open     = 1'b0;

        // Reset asserted mid-clock
        apply_reset("reset");
        check("reset_S1", {31'd0, S1}, 1);

        // Single hop to floor 2, then hold
        for (int i = 0; i < T; i++) step(2'd2, 1'b0, "hop");
        check("hop_floor", {29'd0, floor}, 2);
        for (int i = 0; i < 3; i++) step(2'd1, 1'b0, "hop_hold");

        // Full climb and overrun
        apply_reset("climb_reset");
        for (int i = 0; i < 26; i++) step(2'd2, 1'b0, "climb");
        check("climb_floor", {29'd0, floor}, 4);
        check("climb_fault", {31'd0, fault}, 1);

        // Door dwell at floor 2 with an up command while open
        apply_reset("dwell_reset");
        for (int i = 0; i < T; i++) step(2'd2, 1'b0, "dwell_go");
        step(2'd1, 1'b1, "dwell_pulse");
        step(2'd1, 1'b0, "dwell_c1");
        step(2'd2, 1'b0, "dwell_c2_up");
        for (int i = 0; i < 3; i++) step(2'd1, 1'b0, "dwell_wait");
        for (int i = 0; i < 3; i++) step(2'd2, 1'b0, "dwell_after");
        check("dwell_fault", {31'd0, fault}, 0);

        // Door held past the dwell
        for (int i = 0; i < T - 3; i++) step(2'd2, 1'b0, "hold_go");
        for (int i = 0; i < DC + 3; i++) step(2'd1, 1'b1, "hold_open");
        step(2'd1, 1'b0, "hold_close");
        step(2'd0, 1'b0, "hold_down");

        // Reversal with an off-mark open request
        apply_reset("rev_reset");
        for (int i = 0; i < 3; i++) step(2'd2, 1'b0, "rev_up");
        step(2'd1, 1'b1, "rev_bad_open");
        check("rev_fault", {31'd0, fault}, 1);
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, "rev_down");
        check("rev_S1", {31'd0, S1}, 1);

        // Async reset mid-travel at pos 13
        apply_reset("mid_reset0");
        for (int i = 0; i < 13; i++) step(2'd2, 1'b0, "mid_up");
        check("mid_between", {28'd0, S4, S3, S2, S1}, 0);
        apply_reset("mid_reset");

        // Random commands with periodic resets
        for (int i = 0; i < 600; i++) begin
            int         r;
            logic [1:0] a;
            logic       o;
            r = $urandom_range(0, 99);
            if      (r < 40) a = 2'd2;
            else if (r < 65) a = 2'd0;
            else if (r < 97) a = 2'd1;
            else             a = 2'd3;
            if (a == 2'd1 && (m_pos % T == 0)) o = 1'($urandom_range(0, 1));
            else                              o = ($urandom_range(0, 19) == 0);
            step(a, o, "rand");
            if (i % 75 == 74) apply_reset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
